instr_fetch: RTL and testbench

Instruction fetch stage for the MIPS datapath, sitting directly upstream of the control unit and decode. Holds the PC and fetches words from instruction memory through a ready/request handshake. Presents one instruction at a time to decode. Redirects the PC using the branch/jump decisions that decode returns for the presented instruction.

---
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// MIPS instruction fetch: holds the PC, fetches one word at a time, and presents it to decode.
// Optional build macro IFETCH_ALIGN_CHECK_EN traps misaligned JR targets in a sticky FAULT state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  // Handshakes: a fetch completes on a cycle with imem_req & imem_ready, and imem_addr
  // is held until then. Decode takes the instruction on a cycle with instr_valid & !stall.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] jr_pc;
  logic [31:0] br_offset;
  logic        to_fault;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign jr_pc    = jr_target;
  assign to_fault = jump_reg && (jr_target[1:0] != 2'b00);
`else
  assign jr_pc    = {jr_target[31:2], 2'b00};
  assign to_fault = 1'b0;
`endif

  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)
      next_pc = jr_pc;
    else if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + br_offset;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr <= imem_rdata;
            state <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            pc    <= next_pc;
            state <= to_fault ? FAULT : FETCH;
          end
        end
        FAULT: state <= FAULT;
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);
  assign dbg_state   = state;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_fault = (state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch/accept traffic
// compared against a transaction-level PC model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        imem_req, imem_ready, instr_valid, stall;
  logic        branch_taken, jump, jump_reg, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, jr_target;
  logic [1:0]  dbg_state;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
    .jr_target(jr_target), .fetch_fault(fetch_fault), .dbg_state(dbg_state)
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] cur_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference: next PC from the MIPS redirect rules
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input bit br, input bit j, input bit jr,
                                             input logic [31:0] tgt);
    logic [31:0] p4;
    shortint     imm;
    p4 = p + 32'd4;
    if (jr) return ALIGN ? tgt : (tgt & 32'hFFFF_FFFC);
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br) begin
      imm = shortint'(ins[15:0]);
      return p4 + 32'(int'(imm) * 4);
    end
    return p4;
  endfunction

  // driver tasks
  task automatic noise();
    imem_rdata   = $urandom;
    branch_taken = 1'($urandom_range(0, 1));
    jump         = 1'($urandom_range(0, 1));
    jump_reg     = 1'($urandom_range(0, 1));
    jr_target    = $urandom;
  endtask

  task automatic quiet();
    imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; jump_reg = 1'b0; jr_target = 32'h0; imem_rdata = 32'h0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      noise();
      imem_ready = 1'b1;
      stall = 1'($urandom_range(0, 1));
      step();
      check("rst_pc", pc, RST_PC);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_req", 32'(imem_req), 32'd1);
    end
    rst_n = 1'b1;
    quiet();
    m_pc = RST_PC;
    exp_q.delete();
  endtask

  task automatic do_fetch(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      noise();
      imem_ready = 1'b0;
      stall = 1'($urandom_range(0, 1));
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, m_pc);
      check("wait_valid", 32'(instr_valid), 32'd0);
      step();
    end
    noise();
    imem_ready = 1'b1;
    imem_rdata = data;
    stall = 1'($urandom_range(0, 1));
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, m_pc);
    exp_q.push_back(data);
    step();
    quiet();
    cur_instr = data;
    check("valid", 32'(instr_valid), 32'd1);
    check("instr", instr, exp_q.pop_front());
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("valid_req", 32'(imem_req), 32'd0);
  endtask

  task automatic do_accept(input int stalls, input bit br, input bit j, input bit jr,
                           input logic [31:0] tgt);
    bit exp_fault;
    for (int i = 0; i < stalls; i++) begin
      noise();
      stall = 1'b1;
      step();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, m_pc);
      check("stall_instr", instr, cur_instr);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0; branch_taken = br; jump = j; jump_reg = jr; jr_target = tgt;
    exp_fault = ALIGN && jr && (tgt[1:0] != 2'b00);
    m_pc = model_next(m_pc, cur_instr, br, j, jr, tgt);
    step();
    quiet();
    check("acc_valid", 32'(instr_valid), 32'd0);
    check("acc_fault", 32'(fetch_fault), 32'(exp_fault));
    check("acc_pc", pc, m_pc);
    check("acc_req", 32'(imem_req), exp_fault ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [31:0] tgt;
    quiet();
    do_reset(2);

    // sequential zero-wait fetches from the reset PC
    for (int k = 0; k < 3; k++) begin
      do_fetch(0, 32'h0000_0020);
      do_accept(0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    do_fetch(3, 32'h0000_0020);

    // JR (with jump/branch also set) to 0x200, then BEQ back to itself
    do_accept(0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    do_fetch(0, 32'h1000_FFFF);
    do_accept(0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("beq_addr", imem_addr, 32'h0000_0200);
    do_fetch(1, 32'h1000_FFFF);
    do_accept(2, 1'b1, 1'b0, 1'b0, 32'h0);

    // J to itself at 0x1000_0040, then JR to 0x3000
    do_fetch(0, 32'h0000_0008);
    do_accept(0, 1'b0, 1'b1, 1'b1, 32'h1000_0040);
    do_fetch(0, 32'h0800_0010);
    do_accept(0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("j_addr", imem_addr, 32'h1000_0040);
    do_fetch(0, 32'h0000_0008);
    do_accept(0, 1'b0, 1'b1, 1'b1, 32'h0000_3000);
    check("jr_addr", imem_addr, 32'h0000_3000);

    // PC wrap
    do_fetch(0, 32'h0000_0008);
    do_accept(0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    do_fetch(0, 32'h0000_0020);
    do_accept(0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      do_fetch($urandom_range(0, 3), $urandom);
      tgt = $urandom;
      if (ALIGN) tgt = tgt & 32'hFFFF_FFFC;
      do_accept($urandom_range(0, 2), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), tgt);
    end

    // reset while a response is on the bus, and while an instruction is presented
    do_reset(1);
    check("post_rst_addr", imem_addr, RST_PC);
    do_fetch(1, $urandom);
    do_reset(1);
    do_fetch(0, 32'h0000_0020);

    // misaligned JR
    do_accept(0, 1'b0, 1'b1, 1'b1, 32'h0000_3002);
    if (ALIGN) begin
      for (int i = 0; i < 3; i++) begin
        noise();
        imem_ready = 1'b1;
        step();
        check("fault_hold", 32'(fetch_fault), 32'd1);
        check("fault_req", 32'(imem_req), 32'd0);
        check("fault_valid", 32'(instr_valid), 32'd0);
      end
      do_reset(1);
    end else begin
      check("mis_jr_addr", imem_addr, 32'h0000_3000);
      do_fetch(1, 32'h0000_0020);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
